// File: rtl/sccb_config_if.sv
// Signal bundle between the SCCB configuration master and its ROM and camera pins.
// The master modport is the controller side. The slave modport is the ROM/pad/host side.
interface sccb_config_if;
    logic        START;
    logic [5:0]  ROM_ADDR;
    logic [15:0] ROM_DATA;
    logic        SIOC;
    logic        SIOD_OUT;
    logic        SIOD_OE;
    logic        BUSY;
    logic        DONE;
    logic [2:0]  dbg_state;

    // START is a one-cycle request that is honoured only while the controller is idle or finished.
    // BUSY and DONE are registered status levels. No ready signal exists: a START that arrives
    // while BUSY=1 is dropped. ROM_DATA must be valid one cycle after ROM_ADDR changes.
    modport master (
        input  START, ROM_DATA,
        output ROM_ADDR, SIOC, SIOD_OUT, SIOD_OE, BUSY, DONE, dbg_state
    );

    modport slave (
        output START, ROM_DATA,
        input  ROM_ADDR, SIOC, SIOD_OUT, SIOD_OE, BUSY, DONE, dbg_state
    );
endinterface

// File: rtl/sccb_config.sv
// SCCB write-only configuration master: walks a 64-entry {reg, value} table and writes each entry
// to the camera as a 3-phase frame. The table also supports delay entries and terminator entries.
module sccb_config #(
    parameter int unsigned CLK_DIV      = 125,
    parameter logic [7:0]  DEV_ADDR     = 8'h42,
    parameter int unsigned DELAY_CYCLES = 500000
) (
    input logic CLK,
    input logic RST,
    sccb_config_if.master bus
);
    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE, FETCH, START_C, BITS, STOP_C, GAP, DELAY, FIN
    } state_t;

    state_t        state;
    logic [TW-1:0] tcnt;
    logic [1:0]    phase;
    logic [4:0]    bit_idx;
    logic [26:0]   shreg;
    logic [31:0]   dcnt;
    logic          fetch_wait;

    logic running;
    logic tick;
    logic x_bit;
    logic last_entry;

    // The tick counter restarts from 0 at every frame. As a result, the start condition always
    // lands exactly CLK_DIV cycles after the FETCH decode.
    assign running    = (state == START_C) || (state == BITS) || (state == STOP_C) || (state == GAP);
    assign tick       = running && (tcnt == TW'(CLK_DIV - 1));
    assign x_bit      = (bit_idx == 5'd8) || (bit_idx == 5'd17) || (bit_idx == 5'd26);
    assign last_entry = (bus.ROM_ADDR == 6'd63);
    assign bus.dbg_state = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            tcnt         <= '0;
            phase        <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            dcnt         <= '0;
            fetch_wait   <= 1'b0;
            bus.ROM_ADDR <= '0;
            bus.SIOC     <= 1'b1;
            bus.SIOD_OUT <= 1'b1;
            bus.SIOD_OE  <= 1'b1;
            bus.BUSY     <= 1'b0;
            bus.DONE     <= 1'b0;
        end else begin
            tcnt <= (running && !tick) ? tcnt + TW'(1) : '0;
            case (state)
                IDLE, FIN: begin
                    if (bus.START) begin
                        state        <= FETCH;
                        fetch_wait   <= 1'b0;
                        bus.ROM_ADDR <= '0;
                        bus.BUSY     <= 1'b1;
                        bus.DONE     <= 1'b0;
                    end
                end
                FETCH: begin
                    fetch_wait <= 1'b1;
                    if (fetch_wait) begin
                        fetch_wait <= 1'b0;
                        if (bus.ROM_DATA == 16'hFFFF) begin
                            state    <= FIN;
                            bus.BUSY <= 1'b0;
                            bus.DONE <= 1'b1;
                        end else if (bus.ROM_DATA == 16'hFFF0) begin
                            state <= DELAY;
                            dcnt  <= '0;
                        end else begin
                            state <= START_C;
                            phase <= '0;
                            shreg <= {DEV_ADDR, 1'b1, bus.ROM_DATA[15:8], 1'b1, bus.ROM_DATA[7:0], 1'b1};
                        end
                    end
                end
                START_C: begin
                    if (tick) begin
                        if (phase == 2'd0) begin
                            bus.SIOD_OUT <= 1'b0;
                            phase        <= 2'd1;
                        end else begin
                            bus.SIOC <= 1'b0;
                            state    <= BITS;
                            phase    <= '0;
                            bit_idx  <= '0;
                        end
                    end
                end
                BITS: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        case (phase)
                            2'd0: begin
                                bus.SIOC     <= 1'b0;
                                bus.SIOD_OUT <= shreg[26];
                                bus.SIOD_OE  <= !x_bit;
                                shreg        <= {shreg[25:0], 1'b0};
                            end
                            2'd1: bus.SIOC <= 1'b0;
                            2'd2: bus.SIOC <= 1'b1;
                            default: begin
                                bus.SIOC <= 1'b1;
                                if (bit_idx == 5'd26) begin
                                    state <= STOP_C;
                                end else begin
                                    bit_idx <= bit_idx + 5'd1;
                                end
                            end
                        endcase
                    end
                end
                STOP_C: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        case (phase)
                            2'd0: begin
                                bus.SIOC     <= 1'b0;
                                bus.SIOD_OUT <= 1'b0;
                                bus.SIOD_OE  <= 1'b1;
                            end
                            2'd1: bus.SIOC <= 1'b1;
                            default: begin
                                bus.SIOD_OUT <= 1'b1;
                                state        <= GAP;
                                phase        <= '0;
                            end
                        endcase
                    end
                end
                GAP: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        if (phase == 2'd3) begin
                            if (last_entry) begin
                                state    <= FIN;
                                bus.BUSY <= 1'b0;
                                bus.DONE <= 1'b1;
                            end else begin
                                state        <= FETCH;
                                fetch_wait   <= 1'b0;
                                bus.ROM_ADDR <= bus.ROM_ADDR + 6'd1;
                            end
                        end
                    end
                end
                DELAY: begin
                    // The bus stays at its idle level here, so no output is touched.
                    if (dcnt == DELAY_CYCLES - 1) begin
                        if (last_entry) begin
                            state    <= FIN;
                            bus.BUSY <= 1'b0;
                            bus.DONE <= 1'b1;
                        end else begin
                            state        <= FETCH;
                            fetch_wait   <= 1'b0;
                            bus.ROM_ADDR <= bus.ROM_ADDR + 6'd1;
                        end
                    end else begin
                        dcnt <= dcnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sccb_config.sv
// Randomised scoreboard bench for sccb_config: a table model predicts the frames and a bus
// monitor decodes SIOC/SIOD back into frames and checks the timing.
module tb_sccb_config;
  localparam int         CLK_DIV      = 2;
  localparam logic [7:0] DEV          = 8'h42;
  localparam int         DELAY_CYCLES = 10;
  localparam int         W            = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  sccb_config_if bus();

  sccb_config #(.CLK_DIV(CLK_DIV), .DEV_ADDR(DEV), .DELAY_CYCLES(DELAY_CYCLES)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Synchronous ROM: data follows the address by one clock.
  logic [15:0] rom [64];
  always @(posedge CLK) bus.ROM_DATA <= rom[bus.ROM_ADDR];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: walk the table as the sequence is defined and queue the expected writes.
  logic [W-1:0] exp_q[$];
  int exp_final_addr;

  function automatic void model_push();
    exp_final_addr = 63;
    for (int i = 0; i < 64; i++) begin
      if (rom[i] == 16'hFFFF) begin
        exp_final_addr = i;
        break;
      end
      if (rom[i] != 16'hFFF0) exp_q.push_back(rom[i]);
    end
  endfunction

  function automatic logic [26:0] exp_oe_mask();
    logic [26:0] m;
    for (int i = 0; i < 27; i++) m[26 - i] = ((i % 9) != 8);
    return m;
  endfunction

  // Bus monitor: decodes frames at negedge and checks bit timing and SIOD stability.
  logic        sioc, siod, oe;
  logic        p_sioc = 1'b1;
  logic        p_siod = 1'b1;
  bit          in_frame = 1'b0;
  bit          is_start, is_stop;
  int          mon_nbits = 0;
  int          mon_frames = 0;
  int          last_rise = 0;
  int          oe_low_cyc = 0;
  int          idle_oe_err = 0;
  int          first_sc_cyc = -1;
  logic [26:0] fbits, foe;

  always @(negedge CLK) begin
    sioc = bus.SIOC;
    siod = bus.SIOD_OUT;
    oe   = bus.SIOD_OE;
    if (RST) begin
      in_frame  = 1'b0;
      mon_nbits = 0;
    end else begin
      is_start = sioc && p_sioc && p_siod && !siod;
      is_stop  = sioc && p_sioc && !p_siod && siod;
      if (siod != p_siod && !is_start && !is_stop) check("siod_timing", sioc, 1'b0);
      if (is_start) begin
        check("nested_start", in_frame, 1'b0);
        in_frame   = 1'b1;
        mon_nbits  = 0;
        oe_low_cyc = 0;
        if (first_sc_cyc < 0) first_sc_cyc = cyc;
      end else if (is_stop) begin
        check("stray_stop", in_frame, 1'b1);
        if (in_frame) begin
          check("stop_bitcount", mon_nbits, 27);
          check("dev_addr", fbits[26:19], DEV);
          check("oe_pattern", foe, exp_oe_mask());
          check("oe_low_cycles", oe_low_cyc, 3 * 4 * CLK_DIV);
          if (exp_q.size() == 0) check("unexpected_frame", {fbits[17:10], fbits[8:1]}, 32'hFFFF_FFFF);
          else check("frame", {fbits[17:10], fbits[8:1]}, exp_q.pop_front());
          mon_frames++;
        end
        in_frame = 1'b0;
      end else if (in_frame) begin
        if (!oe) oe_low_cyc++;
        if (!p_sioc && sioc && mon_nbits < 27) begin
          if (mon_nbits > 0) check("bit_period", cyc - last_rise, 4 * CLK_DIV);
          last_rise = cyc;
          fbits[26 - mon_nbits] = siod;
          foe[26 - mon_nbits]   = oe;
          mon_nbits++;
        end
      end else if (!oe) begin
        idle_oe_err++;
      end
    end
    p_sioc = sioc;
    p_siod = siod;
  end

  // Driver tasks.
  task automatic fill_random(input int len, input bit allow_delay);
    logic [15:0] v;
    for (int i = 0; i < 64; i++) begin
      v = 16'($urandom_range(0, 32'hFFEF));
      if (allow_delay && $urandom_range(0, 4) == 0) v = 16'hFFF0;
      rom[i] = v;
    end
    if (len < 64) rom[len] = 16'hFFFF;
  endtask

  task automatic run_table(input int spurious, output int lat);
    int sp;
    bit ok;
    model_push();
    sp = spurious;
    first_sc_cyc = -1;
    idle_oe_err = 0;
    @(negedge CLK);
    bus.START = 1'b1;
    lat = cyc;
    @(negedge CLK);
    bus.START = 1'b0;
    check("start_busy", bus.BUSY, 1'b1);
    check("start_done", bus.DONE, 1'b0);
    check("start_rom_addr", bus.ROM_ADDR, 6'd0);
    ok = 1'b0;
    for (int c = 0; c < 40000; c++) begin
      @(negedge CLK);
      bus.START = 1'b0;
      if (bus.DONE) begin
        ok = 1'b1;
        break;
      end
      if (sp > 0 && bus.BUSY && $urandom_range(0, 99) == 0) begin
        bus.START = 1'b1;
        sp--;
      end
    end
    bus.START = 1'b0;
    check("done_timeout", ok, 1'b1);
    check("fin_busy", bus.BUSY, 1'b0);
    check("fin_rom_addr", bus.ROM_ADDR, exp_final_addr);
    check("frames_left", exp_q.size(), 0);
    check("fin_bus_idle", {bus.SIOC, bus.SIOD_OUT, bus.SIOD_OE}, 3'b111);
    check("idle_oe", idle_oe_err, 0);
    lat = (first_sc_cyc < 0) ? -1 : first_sc_cyc - lat;
  endtask

  int lat_a, lat_b, lat_x, f0;
  bit ok;

  initial begin
    bus.START = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 16'hFFFF;

    // Reset state.
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_sioc", bus.SIOC, 1'b1);
    check("rst_siod", bus.SIOD_OUT, 1'b1);
    check("rst_oe", bus.SIOD_OE, 1'b1);
    check("rst_busy", bus.BUSY, 1'b0);
    check("rst_done", bus.DONE, 1'b0);
    check("rst_rom_addr", bus.ROM_ADDR, 6'd0);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    check("idle_no_start_busy", bus.BUSY, 1'b0);

    // One write followed by the terminator.
    rom[0] = 16'h1280;
    rom[1] = 16'hFFFF;
    f0 = mon_frames;
    run_table(0, lat_a);
    check("single_frame_count", mon_frames - f0, 1);

    // A delay entry ahead of the write pushes the start condition later by the delay
    // plus one extra fetch.
    rom[0] = 16'hFFF0;
    rom[1] = 16'h1100;
    rom[2] = 16'hFFFF;
    f0 = mon_frames;
    run_table(0, lat_b);
    check("delay_frame_count", mon_frames - f0, 1);
    check("delay_latency", lat_b - lat_a, DELAY_CYCLES + 2);

    // Random short tables, including delays, with stray STARTs while busy.
    for (int r = 0; r < 5; r++) begin
      fill_random($urandom_range(1, 10), 1'b1);
      run_table(3, lat_x);
    end

    // Table without a terminator: all 64 entries, then FIN at address 63.
    fill_random(64, 1'b0);
    f0 = mon_frames;
    run_table(2, lat_x);
    check("full_table_frames", mon_frames - f0, 64);
    repeat (100) @(negedge CLK);
    check("no_wrap_frames", mon_frames - f0, 64);
    check("no_wrap_rom_addr", bus.ROM_ADDR, 6'd63);

    // Reset in the middle of a frame aborts without a stop condition.
    fill_random(3, 1'b0);
    @(negedge CLK);
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge CLK);
      if (in_frame && mon_nbits >= 10) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_bit10_timeout", ok, 1'b1);
    f0 = mon_frames;
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("abort_sioc", bus.SIOC, 1'b1);
    check("abort_siod", bus.SIOD_OUT, 1'b1);
    check("abort_busy", bus.BUSY, 1'b0);
    check("abort_rom_addr", bus.ROM_ADDR, 6'd0);
    RST = 1'b0;
    exp_q.delete();
    repeat (50) @(negedge CLK);
    check("abort_no_frame", mon_frames - f0, 0);
    run_table(0, lat_x);
    check("restart_frames", mon_frames - f0, 3);

    // A reset that arrives together with START wins over it.
    @(negedge CLK);
    RST = 1'b1;
    bus.START = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    bus.START = 1'b0;
    check("rst_prio_busy", bus.BUSY, 1'b0);
    check("rst_prio_done", bus.DONE, 1'b0);
    repeat (10) @(negedge CLK);
    check("rst_prio_stays_idle", bus.BUSY, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sccb_config.md
SCCB_CONFIG -- requirements
Module: sccb_config

Interface
REQ-001 Parameter CLK_DIV, default 125, means the number of CLK cycles per SCCB quarter-bit tick (50 MHz / (4*125) = 100 kHz SIOC).
REQ-002 Parameter DEV_ADDR, default 8'h42, means the camera SCCB write ID byte.
REQ-003 Parameter DELAY_CYCLES, default 500000, means the CLK-cycle wait executed for a delay table entry.
REQ-004 Port CLK  input  1  system clock; all logic on its rising edge.
REQ-005 Port RST  input  1  synchronous, active-high reset.
REQ-006 Port START  input  1  single-cycle pulse that begins the configuration sequence from table entry 0.
REQ-007 Port ROM_ADDR  output  6  register-table index.
REQ-008 Port ROM_DATA  input  16  table entry {reg_addr[15:8], value[7:0]}, valid 1 CLK after ROM_ADDR changes.
REQ-009 Port SIOC  output  1  SCCB clock.
REQ-010 Port SIOD_OUT  output  1  SCCB data value.
REQ-011 Port SIOD_OE  output  1  SCCB data drive enable; the top level tristates SIOD when 0.
REQ-012 Port BUSY  output  1  sequence in progress.
REQ-013 Port DONE  output  1  sequence complete; held until the next START or RST.

Function
REQ-014 Tick generator shall count 0..CLK_DIV-1 and emit a one-cycle tick at CLK_DIV-1; counter held at 0 in IDLE/DONE states.
REQ-015 FSM states: IDLE, FETCH, START_C, BITS, STOP_C, GAP, DELAY, FIN.
REQ-016 IDLE/FIN + START -> FETCH with ROM_ADDR=0, BUSY=1, DONE=0; START in any other state shall be ignored.
REQ-017 FETCH shall wait 2 CLK cycles, latch ROM_DATA, then decode: 16'hFFFF -> FIN; 16'hFFF0 -> DELAY; otherwise -> START_C.
REQ-018 START_C (2 ticks): tick 1 SIOD_OUT 1->0 with SIOC=1; tick 2 SIOC=0.
REQ-019 BITS shall shift 27 bits MSB-first: DEV_ADDR, X, reg_addr, X, value, X, where X is the don't-care bit.
REQ-020 Each bit spans 4 ticks: q0 SIOC=0 and SIOD updated; q1 SIOC=0; q2 SIOC=1; q3 SIOC=1; next bit begins at q0.
REQ-021 During the three X bits, SIOD_OE shall be 0; SIOD is ignored and no acknowledge is checked. SIOD_OE shall be 1 at all other times.
REQ-022 STOP_C (3 ticks): SIOC=0/SIOD=0; SIOC=1/SIOD=0; SIOC=1/SIOD=1.
REQ-023 GAP shall hold SIOC=1, SIOD=1 for 4 ticks, then increment ROM_ADDR and -> FETCH.
REQ-024 DELAY shall hold the bus idle for exactly DELAY_CYCLES CLK cycles (32-bit counter), then increment ROM_ADDR and -> FETCH.
REQ-025 After entry 63 completes (write or delay) without a terminator, the block shall go to FIN; ROM_ADDR shall not wrap to 0.
REQ-026 FIN shall set BUSY=0, DONE=1, keep the bus idle and ROM_ADDR unchanged, and accept START as a restart.
REQ-027 Bus-idle level (IDLE, GAP, DELAY, FIN) shall be SIOC=1, SIOD_OUT=1, SIOD_OE=1.

Reset
REQ-028 RST=1 shall, on the next CLK edge, force state IDLE, SIOC=1, SIOD_OUT=1, SIOD_OE=1, BUSY=0, DONE=0, ROM_ADDR=0, and clear the tick, bit and delay counters.
REQ-029 RST asserted mid-transfer shall abort immediately without issuing a stop condition; RST shall take priority over a simultaneous START.

Verification
REQ-030 CLK_DIV=2; table {16'h1280, 16'hFFFF}; START -> one frame with SIOD bits 0x42,X,0x12,X,0x80,X; SIOD_OE=0 during exactly 3 bit periods; then DONE=1, BUSY=0, ROM_ADDR=1.
REQ-031 Timing check on the REQ-030 frame -> SIOD transitions only while SIOC=0, except the start edge (1->0) and stop edge (0->1) with SIOC=1; each bit lasts exactly 4*CLK_DIV CLK cycles.
REQ-032 DELAY_CYCLES=10; table {16'hFFF0, 16'h1100, 16'hFFFF} -> no SIOC edge for 10 cycles after the FETCH decode, then a single write of reg 0x11 value 0x00, then DONE.
REQ-033 Table with no terminator (64 writes) -> 64 frames; ROM_ADDR=63 at FIN; DONE=1; no frame issued for entry 0 a second time.
REQ-034 RST pulse during bit 10 of a frame -> next cycle SIOC=1, SIOD_OUT=1, BUSY=0, ROM_ADDR=0; a later START restarts at entry 0.
REQ-035 START pulses while BUSY=1 -> no effect on sequence or ROM_ADDR; START while DONE=1 -> DONE=0, BUSY=1, ROM_ADDR=0.
